uart_rx_fifo: RTL and testbench

//  Receive-side byte buffer between the UART wrapper and the CPU/IO bus.

---
 rtl/uart_rx_fifo_if.sv | 28 ++
 rtl/uart_rx_fifo.sv | 53 +++++
 tb/tb_uart_rx_fifo.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: bus between the UART wrapper / CPU side and the receive FIFO.
//   master: drives rx_data, rx_data_wr, rd_en, ovf_clr; observes rd_data, empty, full, count, overflow
//   slave : the FIFO itself (opposite directions)
//   line_rdy exists only when UART_RX_FIFO_LF_EN is defined.
interface uart_rx_fifo_if #(parameter int DEPTH = 16);
   localparam int AW = $clog2(DEPTH);
   logic [7:0]  rx_data;
   logic        rx_data_wr;
   logic        rd_en;
   logic        ovf_clr;
   logic [7:0]  rd_data;
   logic        empty;
   logic        full;
   logic [AW:0] count;
   logic        overflow;
`ifdef UART_RX_FIFO_LF_EN
   logic        line_rdy;
   modport master (output rx_data, rx_data_wr, rd_en, ovf_clr,
                   input  rd_data, empty, full, count, overflow, line_rdy);
   modport slave  (input  rx_data, rx_data_wr, rd_en, ovf_clr,
                   output rd_data, empty, full, count, overflow, line_rdy);
`else
   modport master (output rx_data, rx_data_wr, rd_en, ovf_clr,
                   input  rd_data, empty, full, count, overflow);
   modport slave  (input  rx_data, rx_data_wr, rd_en, ovf_clr,
                   output rd_data, empty, full, count, overflow);
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive byte FIFO with fill level and sticky overflow.
//   sys_clk, rst_n (async, active-low); bus: uart_rx_fifo_if.slave
//   Optional UART_RX_FIFO_LF_EN: counts buffered 8'h0A bytes and drives bus.line_rdy.
module uart_rx_fifo #(
   parameter int DEPTH = 16
) (
   input logic            sys_clk,
   input logic            rst_n,
   uart_rx_fifo_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   cnt;
   logic          ovf;
   logic          empty_i, full_i, push_ok, pop_ok;
   assign empty_i = cnt == '0;
   assign full_i  = cnt == (AW+1)'(DEPTH);
   assign pop_ok  = bus.rd_en & ~empty_i;
   // a full FIFO still accepts a push when a pop frees a slot in the same cycle
   assign push_ok = bus.rx_data_wr & (~full_i | pop_ok);
   always_ff @(posedge sys_clk)
      if (push_ok) mem[wr_ptr] <= bus.rx_data;
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         if (push_ok != pop_ok) cnt <= push_ok ? cnt + 1'b1 : cnt - 1'b1;
         if (bus.rx_data_wr & ~push_ok) ovf <= 1'b1;
         else if (bus.ovf_clr) ovf <= 1'b0;
      end
   // storage is not reset, so mask the head while empty to give 8'h00 out of reset
   assign bus.rd_data  = empty_i ? 8'h00 : mem[rd_ptr];
   assign bus.empty    = empty_i;
   assign bus.full     = full_i;
   assign bus.count    = cnt;
   assign bus.overflow = ovf;
`ifdef UART_RX_FIFO_LF_EN
   logic [AW:0] lf_cnt;
   logic        push_lf, pop_lf;
   assign push_lf = push_ok & (bus.rx_data == 8'h0A);
   assign pop_lf  = pop_ok & (bus.rd_data == 8'h0A);
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) lf_cnt <= '0;
      else if (push_lf != pop_lf) lf_cnt <= push_lf ? lf_cnt + 1'b1 : lf_cnt - 1'b1;
   assign bus.line_rdy = lf_cnt != '0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table vectors, corner sequences and random traffic against a queue model.
module tb_uart_rx_fifo;
   localparam int DEPTH = 16;
   logic sys_clk = 1'b0;
   logic rst_n = 1'b0;
   int n_chk = 0;
   int n_pass = 0;
   logic [7:0] q[$];
   logic ovf_m = 1'b0;
   uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();
   uart_rx_fifo #(.DEPTH(DEPTH)) u_dut (.sys_clk(sys_clk), .rst_n(rst_n), .bus(bus));
   always #5 sys_clk = ~sys_clk;
   typedef struct {
      logic       w;
      logic [7:0] d;
      logic       r;
      logic       c;
      int         cnt;
      logic       emp;
      logic       ful;
      logic       ovf;
      int         dat;
   } vec_t;
   vec_t tv[9];
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
      logic pop_m, push_m;
      bus.rx_data_wr = w;
      bus.rx_data    = d;
      bus.rd_en      = r;
      bus.ovf_clr    = c;
      pop_m  = r && q.size() > 0;
      push_m = w && (q.size() < DEPTH || pop_m);
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(d);
      if (w && !push_m) ovf_m = 1'b1;
      else if (c) ovf_m = 1'b0;
      @(posedge sys_clk);
      #1;
      bus.rx_data_wr = 1'b0;
      bus.rd_en      = 1'b0;
      bus.ovf_clr    = 1'b0;
   endtask
   task automatic check_model(input string tag);
      int lf = 0;
      foreach (q[i]) if (q[i] == 8'h0A) lf++;
      chk({tag, "_count"}, int'(bus.count), q.size());
      chk({tag, "_empty"}, int'(bus.empty), int'(q.size() == 0));
      chk({tag, "_full"}, int'(bus.full), int'(q.size() == DEPTH));
      chk({tag, "_ovf"}, int'(bus.overflow), int'(ovf_m));
      if (q.size() > 0) chk({tag, "_data"}, int'(bus.rd_data), int'(q[0]));
`ifdef UART_RX_FIFO_LF_EN
      chk({tag, "_line_rdy"}, int'(bus.line_rdy), int'(lf != 0));
`endif
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      q.delete();
      ovf_m = 1'b0;
      @(posedge sys_clk);
      #1;
      chk("rst_count", int'(bus.count), 0);
      chk("rst_empty", int'(bus.empty), 1);
      chk("rst_full", int'(bus.full), 0);
      chk("rst_ovf", int'(bus.overflow), 0);
      chk("rst_data", int'(bus.rd_data), 0);
`ifdef UART_RX_FIFO_LF_EN
      chk("rst_line_rdy", int'(bus.line_rdy), 0);
`endif
      rst_n = 1'b1;
   endtask
   initial begin
      bus.rx_data_wr = 1'b0;
      bus.rx_data    = 8'h00;
      bus.rd_en      = 1'b0;
      bus.ovf_clr    = 1'b0;
      tv[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 'h41};
      tv[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 'h41};
      tv[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 'h41};
      tv[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 'h42};
      tv[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 'h43};
      tv[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, -1};
      tv[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, -1};
      tv[7] = '{1'b1, 8'h55, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 'h55};
      tv[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, -1};
      #2;
      do_reset();
      foreach (tv[i]) begin
         step(tv[i].w, tv[i].d, tv[i].r, tv[i].c);
         chk($sformatf("tv%0d_count", i), int'(bus.count), tv[i].cnt);
         chk($sformatf("tv%0d_empty", i), int'(bus.empty), int'(tv[i].emp));
         chk($sformatf("tv%0d_full", i), int'(bus.full), int'(tv[i].ful));
         chk($sformatf("tv%0d_ovf", i), int'(bus.overflow), int'(tv[i].ovf));
         if (tv[i].dat >= 0) chk($sformatf("tv%0d_data", i), int'(bus.rd_data), tv[i].dat);
      end
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_full", int'(bus.full), 1);
      chk("fill_ovf", int'(bus.overflow), 0);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("drop_ovf", int'(bus.overflow), 1);
      chk("drop_count", int'(bus.count), 16);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain_%0d", i), int'(bus.rd_data), i);
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("drain_empty", int'(bus.empty), 1);
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      step(1'b1, 8'hAA, 1'b1, 1'b0);
      chk("fullpp_count", int'(bus.count), 16);
      chk("fullpp_ovf", int'(bus.overflow), 0);
      chk("fullpp_full", int'(bus.full), 1);
      for (int i = 1; i < 16; i++) begin
         chk($sformatf("fullpp_%0d", i), int'(bus.rd_data), 8'h10 + i);
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("fullpp_last", int'(bus.rd_data), 'hAA);
      chk("fullpp_last_count", int'(bus.count), 1);
      do_reset();
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 8'(i * 7 + 3), 1'b0, 1'b0);
         chk($sformatf("wrap_cnt1_%0d", i), int'(bus.count), 1);
         chk($sformatf("wrap_data_%0d", i), int'(bus.rd_data), (i * 7 + 3) & 'hFF);
         step(1'b0, 8'h00, 1'b1, 1'b0);
         chk($sformatf("wrap_cnt0_%0d", i), int'(bus.count), 0);
      end
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 8'h33, 1'b0, 1'b0);
      step(1'b1, 8'hFF, 1'b0, 1'b1);
      chk("clr_vs_set", int'(bus.overflow), 1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_alone", int'(bus.overflow), 0);
      chk("clr_count", int'(bus.count), 16);
`ifdef UART_RX_FIFO_LF_EN
      do_reset();
      step(1'b1, 8'h68, 1'b0, 1'b0);
      step(1'b1, 8'h69, 1'b0, 1'b0);
      chk("lf_before", int'(bus.line_rdy), 0);
      step(1'b1, 8'h0A, 1'b0, 1'b0);
      chk("lf_after", int'(bus.line_rdy), 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("lf_pop2", int'(bus.line_rdy), 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("lf_pop3", int'(bus.line_rdy), 0);
      step(1'b1, 8'h0A, 1'b0, 1'b0);
      step(1'b1, 8'h41, 1'b0, 1'b0);
      chk("lf_mid", int'(bus.line_rdy), 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("lf_async_count", int'(bus.count), 0);
      chk("lf_async_line_rdy", int'(bus.line_rdy), 0);
      q.delete();
      ovf_m = 1'b0;
      @(posedge sys_clk);
      #1;
      rst_n = 1'b1;
`endif
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic w, r, c;
         logic [7:0] d;
         w = $urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 40);
         r = $urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 65);
         c = $urandom_range(0, 15) == 0;
         d = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
         step(w, d, r, c);
         check_model($sformatf("rnd%0d", i));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
